// File: rtl/regfile_mp_if.sv
// Decode/write-back bus for the multi-port register file: read ports, two write-back ports,
// issue allocation and a debug peek port.
interface regfile_mp_if #(
  parameter int DW     = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0] REG_address_rd;
  logic [NUM_RD*DW-1:0] REG_data_rd;
  logic [NUM_RD-1:0]    REG_busy_rd;
  logic                 REG_write_0;
  logic [AW-1:0]        REG_address_wr0;
  logic [DW-1:0]        REG_data_wb_in0;
  logic                 REG_write_1;
  logic [AW-1:0]        REG_address_wr1;
  logic [DW-1:0]        REG_data_wb_in1;
  logic                 REG_issue;
  logic [AW-1:0]        REG_address_issue;
  logic [AW-1:0]        test_address_register;
  logic [DW-1:0]        test_value_register;

  modport master (
    output REG_address_rd, REG_write_0, REG_address_wr0, REG_data_wb_in0,
           REG_write_1, REG_address_wr1, REG_data_wb_in1,
           REG_issue, REG_address_issue, test_address_register,
    input  REG_data_rd, REG_busy_rd, test_value_register
  );

  modport slave (
    input  REG_address_rd, REG_write_0, REG_address_wr0, REG_data_wb_in0,
           REG_write_1, REG_address_wr1, REG_data_wb_in1,
           REG_issue, REG_address_issue, test_address_register,
    output REG_data_rd, REG_busy_rd, test_value_register
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, two write-back ports (port 1 wins),
// optional hardwired r0 and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic                 we0, we1;
  logic [AW-1:0]        rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [DW-1:0]        test_val;

  assign we0 = bus.REG_write_0 && !(ZERO_REG != 0 && bus.REG_address_wr0 == '0);
  assign we1 = bus.REG_write_1 && !(ZERO_REG != 0 && bus.REG_address_wr1 == '0);

  // Port 1 is written last so its non-blocking update wins on an address conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (we0) mem_q[bus.REG_address_wr0] <= bus.REG_data_wb_in0;
      if (we1) mem_q[bus.REG_address_wr1] <= bus.REG_data_wb_in1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (bus.REG_write_0) busy_d[bus.REG_address_wr0] = 1'b0;
    if (bus.REG_write_1) busy_d[bus.REG_address_wr1] = 1'b0;
    if (bus.REG_issue)   busy_d[bus.REG_address_issue] = 1'b1;
    if (ZERO_REG != 0)   busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Bypassed writes report not-busy, matching the data they forward.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_addr = bus.REG_address_rd[k*AW +: AW];
      if (rst || (ZERO_REG != 0 && rd_addr == '0)) begin
        rd_data[k*DW +: DW] = '0;
        rd_busy[k]          = 1'b0;
      end else if (bus.REG_write_1 && rd_addr == bus.REG_address_wr1) begin
        rd_data[k*DW +: DW] = bus.REG_data_wb_in1;
        rd_busy[k]          = 1'b0;
      end else if (bus.REG_write_0 && rd_addr == bus.REG_address_wr0) begin
        rd_data[k*DW +: DW] = bus.REG_data_wb_in0;
        rd_busy[k]          = 1'b0;
      end else begin
        rd_data[k*DW +: DW] = mem_q[rd_addr];
        rd_busy[k]          = busy_q[rd_addr];
      end
    end
  end

  always_comb begin
    test_val = '0;
    if (!rst) test_val = mem_q[bus.test_address_register];
  end

  assign bus.REG_data_rd         = rd_data;
  assign bus.REG_busy_rd         = rd_busy;
  assign bus.test_value_register = test_val;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector table plus reset/zero-register sequences and a randomised small-config sweep.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_mp_if #(.DW(32), .DEPTH(32), .NUM_RD(2)) m ();
  regfile_mp_if #(.DW(32), .DEPTH(32), .NUM_RD(2)) z ();
  regfile_mp_if #(.DW(16), .DEPTH(8),  .NUM_RD(4)) s ();

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) u_main  (.clk(clk), .rst(rst), .bus(m));
  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) u_nozero(.clk(clk), .rst(rst), .bus(z));
  regfile_mp #(.DW(16), .DEPTH(8),  .NUM_RD(4), .ZERO_REG(1)) u_small (.clk(clk), .rst(rst), .bus(s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        w0; logic [4:0] a0; logic [31:0] d0;
    logic        w1; logic [4:0] a1; logic [31:0] d1;
    logic        iss; logic [4:0] ai;
    logic [4:0]  r0; logic [4:0] r1; logic [4:0] ta;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] eb; logic [31:0] etv;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    m.REG_address_rd = '0; m.REG_write_0 = 1'b0; m.REG_address_wr0 = '0; m.REG_data_wb_in0 = '0;
    m.REG_write_1 = 1'b0; m.REG_address_wr1 = '0; m.REG_data_wb_in1 = '0;
    m.REG_issue = 1'b0; m.REG_address_issue = '0; m.test_address_register = '0;
    z.REG_address_rd = '0; z.REG_write_0 = 1'b0; z.REG_address_wr0 = '0; z.REG_data_wb_in0 = '0;
    z.REG_write_1 = 1'b0; z.REG_address_wr1 = '0; z.REG_data_wb_in1 = '0;
    z.REG_issue = 1'b0; z.REG_address_issue = '0; z.test_address_register = '0;
    s.REG_address_rd = '0; s.REG_write_0 = 1'b0; s.REG_address_wr0 = '0; s.REG_data_wb_in0 = '0;
    s.REG_write_1 = 1'b0; s.REG_address_wr1 = '0; s.REG_data_wb_in1 = '0;
    s.REG_issue = 1'b0; s.REG_address_issue = '0; s.test_address_register = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    m.REG_write_0 = v.w0; m.REG_address_wr0 = v.a0; m.REG_data_wb_in0 = v.d0;
    m.REG_write_1 = v.w1; m.REG_address_wr1 = v.a1; m.REG_data_wb_in1 = v.d1;
    m.REG_issue = v.iss; m.REG_address_issue = v.ai;
    m.REG_address_rd = {v.r1, v.r0}; m.test_address_register = v.ta;
  endtask

  logic [15:0] rm [8];
  logic [7:0]  rb;
  logic [63:0] exp_rd;
  logic [3:0]  exp_bz;
  logic [15:0] exp_tv;
  logic        pulse;
  int          ad;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //        w0   a0     d0             w1   a1     d1          iss  ai     r0     r1     ta     e0             e1             eb     etv
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd3, 32'h33,     1'b0, 5'd0, 5'd5, 5'd7, 5'd3, 32'hDEADBEEF, 32'h11,       2'b00, 32'h33};
    vt[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h22,     1'b0, 5'd0, 5'd7, 5'd3, 5'd7, 32'h22,       32'h33,       2'b00, 32'h22};
    vt[3]  = '{1'b1, 5'd9, 32'hAAAA,     1'b1, 5'd9, 32'h5555,   1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'h5555,     32'h5555,     2'b00, 32'h5555};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd9, 5'd7, 5'd9, 32'h5555,     32'h22,       2'b00, 32'h5555};
    vt[5]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,      1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b1, 5'd4, 5'd4, 5'd5, 5'd4, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd4, 5'd4, 32'h0,        32'h0,        2'b11, 32'h0};
    vt[9]  = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd5, 5'd4, 32'h44,       32'hDEADBEEF, 2'b00, 32'h44};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd4, 5'd4, 32'h44,       32'h44,       2'b00, 32'h44};
    vt[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h45,     1'b1, 5'd4, 5'd4, 5'd4, 5'd4, 32'h45,       32'h45,       2'b00, 32'h45};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd4, 5'd4, 32'h45,       32'h45,       2'b11, 32'h45};
    vt[13] = '{1'b1, 5'd4, 32'h46,       1'b0, 5'd0, 32'h0,      1'b1, 5'd8, 5'd4, 5'd8, 5'd4, 32'h46,       32'h0,        2'b00, 32'h46};
    vt[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd8, 5'd8, 32'h46,       32'h0,        2'b10, 32'h0};

    // Reset held from time 0: bypass suppressed and writes ignored.
    rst = 1'b1;
    idle_all();
    m.REG_write_0 = 1'b1; m.REG_address_wr0 = 5'd5; m.REG_data_wb_in0 = 32'h77;
    m.REG_issue = 1'b1; m.REG_address_issue = 5'd6;
    m.REG_address_rd = {5'd6, 5'd5}; m.test_address_register = 5'd5;
    #2;
    chk("reset_rd", 64'(m.REG_data_rd), 64'h0);
    chk("reset_busy", 64'(m.REG_busy_rd), 64'h0);
    @(posedge clk); #1;
    chk("reset_write_ignored", 64'(m.test_value_register), 64'h0);
    rst = 1'b0;
    idle_all();
    m.REG_address_rd = {5'd6, 5'd6};
    #2;
    chk("reset_issue_ignored", 64'(m.REG_busy_rd), 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      apply_vec(vt[i]);
      #2;
      chk($sformatf("vec%0d_rd", i), 64'(m.REG_data_rd), {vt[i].e1, vt[i].e0});
      chk($sformatf("vec%0d_busy", i), 64'(m.REG_busy_rd), 64'(vt[i].eb));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tv", i), 64'(m.test_value_register), 64'(vt[i].etv));
    end

    // ZERO_REG=0: r0 behaves like any other register.
    idle_all();
    z.REG_write_0 = 1'b1; z.REG_address_wr0 = 5'd0; z.REG_data_wb_in0 = 32'hFFFFFFFF;
    z.REG_issue = 1'b1; z.REG_address_issue = 5'd0;
    z.REG_address_rd = {5'd0, 5'd0}; z.test_address_register = 5'd0;
    #2;
    chk("nozero_bypass", 64'(z.REG_data_rd), 64'hFFFFFFFF_FFFFFFFF);
    chk("nozero_busy_bypass", 64'(z.REG_busy_rd), 64'h0);
    @(posedge clk); #1;
    chk("nozero_tv", 64'(z.test_value_register), 64'hFFFFFFFF);
    z.REG_write_0 = 1'b0; z.REG_issue = 1'b0;
    #2;
    chk("nozero_stored", 64'(z.REG_data_rd), 64'hFFFFFFFF_FFFFFFFF);
    chk("nozero_busy", 64'(z.REG_busy_rd), 64'h3);

    // Asynchronous reset between edges with a write pending.
    @(posedge clk); #1;
    idle_all();
    m.REG_write_0 = 1'b1; m.REG_address_wr0 = 5'd5; m.REG_data_wb_in0 = 32'h12345678;
    m.REG_address_rd = {5'd8, 5'd5}; m.test_address_register = 5'd5;
    #1;
    chk("pre_rst_rd", 64'(m.REG_data_rd), {32'h0, 32'h12345678});
    chk("pre_rst_busy", 64'(m.REG_busy_rd), 64'h2);
    chk("pre_rst_tv", 64'(m.test_value_register), 64'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rd", 64'(m.REG_data_rd), 64'h0);
    chk("async_rst_busy", 64'(m.REG_busy_rd), 64'h0);
    chk("async_rst_tv", 64'(m.test_value_register), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_all();
    m.REG_address_rd = {5'd8, 5'd5}; m.test_address_register = 5'd5;
    #1;
    chk("post_rst_tv", 64'(m.test_value_register), 64'h0);
    chk("post_rst_busy", 64'(m.REG_busy_rd), 64'h0);
    m.REG_write_0 = 1'b1; m.REG_address_wr0 = 5'd2; m.REG_data_wb_in0 = 32'h2;
    m.test_address_register = 5'd2;
    @(posedge clk); #1;
    chk("first_edge_after_rst", 64'(m.test_value_register), 64'h2);
    idle_all();

    // Small configuration against a reference model, with reset pulses.
    for (int a = 0; a < 8; a++) rm[a] = '0;
    rb = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      pulse = (cyc == 500) || ($urandom_range(0, 99) == 0);
      rst = pulse;
      if (pulse) begin
        for (int a = 0; a < 8; a++) rm[a] = '0;
        rb = '0;
      end
      s.REG_address_rd    = 12'($urandom);
      s.REG_write_0       = 1'($urandom_range(0, 1));
      s.REG_address_wr0   = 3'($urandom);
      s.REG_data_wb_in0   = 16'($urandom);
      s.REG_write_1       = 1'($urandom_range(0, 1));
      s.REG_address_wr1   = ($urandom_range(0, 3) == 0) ? s.REG_address_wr0 : 3'($urandom);
      s.REG_data_wb_in1   = 16'($urandom);
      s.REG_issue         = 1'($urandom_range(0, 1));
      s.REG_address_issue = 3'($urandom);
      s.test_address_register = 3'($urandom);
      #2;
      exp_rd = '0;
      exp_bz = '0;
      exp_tv = rst ? 16'h0 : rm[s.test_address_register];
      for (int k = 0; k < 4; k++) begin
        ad = int'(s.REG_address_rd[k*3 +: 3]);
        if (rst || ad == 0) begin
          exp_rd[k*16 +: 16] = 16'h0;
        end else if (s.REG_write_1 && ad == int'(s.REG_address_wr1)) begin
          exp_rd[k*16 +: 16] = s.REG_data_wb_in1;
        end else if (s.REG_write_0 && ad == int'(s.REG_address_wr0)) begin
          exp_rd[k*16 +: 16] = s.REG_data_wb_in0;
        end else begin
          exp_rd[k*16 +: 16] = rm[ad];
          exp_bz[k]          = rb[ad];
        end
      end
      chk($sformatf("sweep%0d_rd", cyc), s.REG_data_rd, exp_rd);
      chk($sformatf("sweep%0d_busy", cyc), 64'(s.REG_busy_rd), 64'(exp_bz));
      chk($sformatf("sweep%0d_tv", cyc), 64'(s.test_value_register), 64'(exp_tv));
      @(posedge clk);
      if (!rst) begin
        if (s.REG_write_0 && s.REG_address_wr0 != 3'd0) rm[s.REG_address_wr0] = s.REG_data_wb_in0;
        if (s.REG_write_1 && s.REG_address_wr1 != 3'd0) rm[s.REG_address_wr1] = s.REG_data_wb_in1;
        if (s.REG_write_0) rb[s.REG_address_wr0] = 1'b0;
        if (s.REG_write_1) rb[s.REG_address_wr1] = 1'b0;
        if (s.REG_issue)   rb[s.REG_address_issue] = 1'b1;
        rb[0] = 1'b0;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
